// File: rtl/pfpu_regf_mp.sv
// pfpu_regf_mp: multi-port register file, one replicated bank per read port,
// with optional read-during-write bypass and a hardware clear sequencer.
module pfpu_regf_mp #(
    parameter int DW             = 32,
    parameter int AW             = 7,
    parameter int NRD            = 2,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [NRD*AW-1:0] rd_a,
    output logic [NRD*DW-1:0] rd_d,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_a,
    input  logic [DW-1:0]     wr_d,
    input  logic              clear_start,
    output logic              busy,
    output logic              clear_done,
    output logic              wr_drop
);
    localparam int DEPTH = 1 << AW;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
    localparam logic [0:0] RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    logic [0:0]    state;
    logic [AW-1:0] cptr;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    assign busy = state == CLEAR;
    // the sequencer owns the shared write port while clearing; external writes are dropped
    always_comb begin
        mem_we = busy | wr_en;
        mem_a  = busy ? cptr : wr_a;
        mem_d  = busy ? '0 : wr_d;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= RST_STATE;
            cptr       <= '0;
            clear_done <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            clear_done <= busy && (&cptr);
            wr_drop    <= busy && wr_en;
            if (busy) begin
                cptr <= cptr + 1'b1;
                if (&cptr) state <= IDLE;
            end else if (clear_start) begin
                cptr  <= '0;
                state <= CLEAR;
            end
        end
    end
    for (genvar g = 0; g < NRD; g++) begin : g_bank
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] q;
        logic [AW-1:0] ra;
        logic          hit;
        assign ra  = rd_a[g*AW +: AW];
        assign hit = (BYPASS != 0) && wr_en && (wr_a == ra);
        assign rd_d[g*DW +: DW] = q;
        always_ff @(posedge sys_clk) begin
            if (mem_we) mem[mem_a] <= mem_d;
        end
        // reads during a clear return zero, the value every word ends up with
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) q <= '0;
            else q <= busy ? '0 : hit ? wr_d : mem[ra];
        end
    end
endmodule

// File: tb/tb_pfpu_regf_mp.sv
// tb_pfpu_regf_mp: three parameter sets run side by side, each compared every cycle
// against a word-array model of the register file plus directed literal checks.
module tb_pfpu_regf_mp;
    logic sys_clk;
    int   errs = 0;
    int   checks = 0;
    int   nfin = 0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void mark_done();
        nfin++;
    endfunction

    for (genvar c = 0; c < 3; c++) begin : cfg
        localparam int DW  = c == 0 ? 32 : c == 1 ? 8 : 64;
        localparam int AW  = c == 0 ? 7 : 4;
        localparam int NRD = c == 0 ? 3 : c == 1 ? 1 : 4;
        localparam int BYP = c == 1 ? 0 : 1;
        localparam int COR = c == 2 ? 1 : 0;
        localparam int D   = 1 << AW;

        logic              rst_n;
        logic [NRD*AW-1:0] rd_a;
        logic [NRD*DW-1:0] rd_d;
        logic              wr_en, clear_start, busy, clear_done, wr_drop;
        logic [AW-1:0]     wr_a;
        logic [DW-1:0]     wr_d;

        pfpu_regf_mp #(.DW(DW), .AW(AW), .NRD(NRD), .BYPASS(BYP), .CLEAR_ON_RESET(COR)) dut (
            .sys_clk(sys_clk), .sys_rst_n(rst_n), .rd_a(rd_a), .rd_d(rd_d),
            .wr_en(wr_en), .wr_a(wr_a), .wr_d(wr_d), .clear_start(clear_start),
            .busy(busy), .clear_done(clear_done), .wr_drop(wr_drop));

        logic [DW-1:0] mm [D];
        bit            mv [D];
        logic [DW-1:0] er [NRD];
        bit            ev [NRD];
        bit            eb, ed, ew, armed;
        int            left, caddr;

        function automatic void mreset();
            for (int i = 0; i < NRD; i++) begin
                er[i] = '0;
                ev[i] = 1'b1;
            end
            ed = 1'b0;
            ew = 1'b0;
            left = COR != 0 ? D : 0;
            caddr = 0;
            eb = left > 0;
        endfunction

        always @(negedge rst_n) mreset();

        always @(posedge sys_clk) begin
            if (rst_n) begin
                if (left > 0) begin
                    for (int i = 0; i < NRD; i++) begin
                        er[i] = '0;
                        ev[i] = 1'b1;
                    end
                    mm[caddr] = '0;
                    mv[caddr] = 1'b1;
                    caddr++;
                    left--;
                    ed = left == 0;
                    ew = wr_en;
                end else begin
                    for (int i = 0; i < NRD; i++) begin
                        logic [AW-1:0] a;
                        a = rd_a[i*AW +: AW];
                        if (BYP != 0 && wr_en && wr_a == a) begin
                            er[i] = wr_d;
                            ev[i] = 1'b1;
                        end else begin
                            er[i] = mm[a];
                            ev[i] = mv[a];
                        end
                    end
                    if (wr_en) begin
                        mm[wr_a] = wr_d;
                        mv[wr_a] = 1'b1;
                    end
                    ed = 1'b0;
                    ew = 1'b0;
                    if (clear_start) begin
                        left = D;
                        caddr = 0;
                    end
                end
                eb = left > 0;
            end
        end

        always @(negedge sys_clk) begin
            if (armed) begin
                chk($sformatf("c%0d busy", c), 256'(busy), 256'(eb));
                chk($sformatf("c%0d clear_done", c), 256'(clear_done), 256'(ed));
                chk($sformatf("c%0d wr_drop", c), 256'(wr_drop), 256'(ew));
                for (int i = 0; i < NRD; i++)
                    if (ev[i]) chk($sformatf("c%0d rd_d[%0d]", c, i), 256'(rd_d[i*DW +: DW]), 256'(er[i]));
            end
        end

        task automatic tick();
            @(negedge sys_clk);
        endtask

        task automatic wait_busy(output int n);
            bit ok;
            ok = 1'b0;
            n = 0;
            for (int j = 0; j < 4 * D; j++) begin
                tick();
                clear_start = 1'b0;
                wr_en = 1'b0;
                if (!busy) begin
                    ok = 1'b1;
                    break;
                end
                n++;
            end
            chk($sformatf("c%0d clear timeout", c), 256'(ok), 256'(1));
        endtask

        task automatic rd_all(input logic [AW-1:0] a);
            rd_a = {NRD{a}};
        endtask

        task automatic rand_phase(input int cyc);
            for (int k = 0; k < cyc; k++) begin
                wr_en = 1'($urandom % 2);
                wr_a = AW'($urandom);
                wr_d = DW'({$urandom, $urandom});
                for (int i = 0; i < NRD; i++)
                    rd_a[i*AW +: AW] = ($urandom % 3 == 0) ? wr_a : AW'($urandom);
                tick();
            end
            wr_en = 1'b0;
        endtask

        task automatic readback();
            for (int a = 0; a < D; a++) begin
                rd_all(AW'(a));
                tick();
            end
            tick();
        endtask

        initial begin
            int n, drops, dones, cyc;
            bit ok;
            armed = 1'b0;
            rst_n = 1'b0;
            rd_a = '0;
            wr_en = 1'b0;
            wr_a = '0;
            wr_d = '0;
            clear_start = 1'b0;
            mreset();
            repeat (3) tick();
            chk($sformatf("c%0d reset busy", c), 256'(busy), 256'(COR));
            chk($sformatf("c%0d reset rd_d", c), 256'(rd_d), 256'(0));
            rst_n = 1'b1;
            clear_start = 1'b1;
            armed = 1'b1;
            wait_busy(n);
            chk($sformatf("c%0d initial clear length", c), 256'(n), 256'(COR != 0 ? D - 1 : D));

            wr_en = 1'b1;
            wr_a = AW'(5);
            wr_d = DW'(32'hDEADBEEF);
            tick();
            wr_en = 1'b0;
            rd_all(AW'(5));
            tick();
            for (int i = 0; i < NRD; i++)
                chk($sformatf("c%0d read 5 port %0d", c, i), 256'(rd_d[i*DW +: DW]), 256'(DW'(32'hDEADBEEF)));
            rd_all(AW'(6));
            tick();
            tick();
            for (int i = 0; i < NRD; i++)
                chk($sformatf("c%0d read 6 port %0d", c, i), 256'(rd_d[i*DW +: DW]), 256'(0));

            wr_en = 1'b1;
            wr_a = AW'(9);
            wr_d = DW'(32'hAAAA);
            tick();
            wr_d = DW'(32'h1234);
            rd_all(AW'(9));
            tick();
            wr_en = 1'b0;
            chk($sformatf("c%0d bypass read", c), 256'(rd_d[DW-1:0]),
                256'(BYP != 0 ? DW'(32'h1234) : DW'(32'hAAAA)));
            tick();
            chk($sformatf("c%0d repeat read", c), 256'(rd_d[DW-1:0]), 256'(DW'(32'h1234)));

            rand_phase(300);

            for (int a = 0; a < D; a++) begin
                wr_en = 1'b1;
                wr_a = AW'(a);
                wr_d = DW'(a);
                tick();
            end
            wr_en = 1'b0;
            clear_start = 1'b1;
            n = 0;
            drops = 0;
            dones = 0;
            ok = 1'b0;
            for (int j = 1; j < 3 * D; j++) begin
                tick();
                clear_start = j == D - 3;
                wr_en = j == 10;
                wr_a = AW'(3);
                wr_d = DW'(8'h55);
                drops += int'(wr_drop);
                dones += int'(clear_done);
                if (!busy) begin
                    chk($sformatf("c%0d done at busy fall", c), 256'(clear_done), 256'(1));
                    ok = 1'b1;
                    break;
                end
                n++;
            end
            chk($sformatf("c%0d fill clear timeout", c), 256'(ok), 256'(1));
            chk($sformatf("c%0d clear length", c), 256'(n), 256'(D));
            chk($sformatf("c%0d drop count", c), 256'(drops), 256'(1));
            chk($sformatf("c%0d done count", c), 256'(dones), 256'(1));
            readback();
            rd_all(AW'(3));
            tick();
            tick();
            chk($sformatf("c%0d addr 3 after clear", c), 256'(rd_d[DW-1:0]), 256'(0));

            rand_phase(50);
            wr_en = 1'b1;
            wr_a = AW'(7);
            wr_d = DW'($urandom) | DW'(1);
            clear_start = 1'b1;
            wait_busy(n);
            chk($sformatf("c%0d simultaneous clear length", c), 256'(n), 256'(D));
            rd_all(AW'(7));
            tick();
            tick();
            chk($sformatf("c%0d addr 7 after simultaneous", c), 256'(rd_d[DW-1:0]), 256'(0));

            rand_phase(100);
            cyc = D > 40 ? 40 : D / 2;
            clear_start = 1'b1;
            tick();
            clear_start = 1'b0;
            repeat (cyc - 1) tick();
            @(posedge sys_clk);
            #2 rst_n = 1'b0;
            #1;
            chk($sformatf("c%0d async reset busy", c), 256'(busy), 256'(COR));
            chk($sformatf("c%0d async reset rd_d", c), 256'(rd_d), 256'(0));
            tick();
            rst_n = 1'b1;
            wait_busy(n);
            chk($sformatf("c%0d busy after reset release", c), 256'(n), 256'(COR != 0 ? D - 1 : 0));
            readback();
            mark_done();
        end
    end

    initial begin
        for (int k = 0; k < 20000; k++) begin
            @(negedge sys_clk);
            if (nfin == 3) break;
        end
        if (nfin != 3) chk("overall timeout", 256'(nfin), 256'(3));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/pfpu_regf_mp.md
# pfpu_regf_mp

Parametrised multi-port register file for the PFPU and later DSP cores. It stores `DEPTH` words of `DW` bits and serves `NRD` independent synchronous read ports from one write port, using one replicated dual-port bank per read port. Compared with the fixed 128x32 two-read-port storage it replaces, it adds:

- configurable read-during-write bypass;
- a hardware clear sequencer, so the PFPU no longer zeroes registers through microcode.

## Interface

Parameters:
- `DW`, 32, data word width (1..64).
- `AW`, 7, address width; `DEPTH` = 2^AW.
- `NRD`, 2, number of read ports (1..4); one bank per port.
- `BYPASS`, 1, 1 = a read of the address written in the same cycle returns the new data; 0 = returns the old data.
- `CLEAR_ON_RESET`, 0, 1 = the clear sequencer starts automatically when reset is released.

Ports:
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sys_rst_n`  in  1  reset, asynchronous and active-low.
- `rd_a`  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- `rd_d`  out  NRD*DW  registered read data; port i uses bits [i*DW +: DW].
- `wr_en`  in  1  write strobe.
- `wr_a`  in  AW  write address.
- `wr_d`  in  DW  write data.
- `clear_start`  in  1  request to zero the whole file; single-cycle pulse.
- `busy`  out  1  clear in progress.
- `clear_done`  out  1  one-cycle pulse when a clear finishes.
- `wr_drop`  out  1  one-cycle pulse when an external write is discarded.

## Operation

- **Banks.** NRD banks of DEPTH x DW. Every write goes to all banks at the same address, so their contents are always identical. Read port i reads only bank i.
- **Read.** `rd_d[i]` <= bank_i[`rd_a[i]`] on every edge, with no enable.
- **Bypass.**
  - BYPASS=1 and `wr_en` & (`wr_a` == `rd_a[i]`): `rd_d[i]` <= `wr_d`.
  - BYPASS=0: old contents (read-before-write).
- **State machine.** Two states, IDLE and CLEAR; a pointer `cptr` of AW bits.
- **IDLE:**
  - `wr_en` writes `wr_d`.
  - `clear_start` sets `cptr` to 0 and moves to CLEAR.
  - If `wr_en` and `clear_start` arrive in the same cycle, the write is performed, then the clear starts.
- **CLEAR:**
  - Each cycle, zero is written to `cptr` in all banks and `cptr` increments.
  - When `cptr` == DEPTH-1 has been written, go to IDLE and pulse `clear_done`.
  - `clear_start` is ignored in this state.
  - Any `wr_en` is discarded and pulses `wr_drop` the next cycle.
- **Reads during CLEAR.** All `rd_d` are forced to 0, which is the value every location holds afterwards. Bypass does not apply.
- **Reset (`sys_rst_n` low, any time including mid-clear):**
  - `rd_d` = 0, `clear_done` = 0, `wr_drop` = 0, `cptr` = 0.
  - State = CLEAR if CLEAR_ON_RESET=1, else IDLE; `busy` reflects that state.
  - Memory contents are not reset. A clear interrupted by reset leaves a partially zeroed file unless CLEAR_ON_RESET=1.
- **Pointer wrap.** Wrap of `cptr` at DEPTH-1 is natural AW-bit overflow; the terminal compare ends the clear.

## Timing

- **Read latency.** 1 cycle: address at edge k gives data valid after edge k.
- **Write.** A write at edge k is visible to a read issued at edge k+1. Visibility of a read issued at edge k itself depends on BYPASS.
- **Clear timing.**
  - `clear_start` is sampled at edge k; `busy` is 1 after edge k.
  - Zero writes to addresses 0..DEPTH-1 occur at edges k+1..k+DEPTH.
  - `busy` is 0 and `clear_done` is 1 after edge k+DEPTH; `clear_done` is 0 after edge k+DEPTH+1.
  - Total busy time: DEPTH cycles (128 for AW=7).
- **First accepted write.** The first external write accepted after a clear is sampled at edge k+DEPTH+1, when `busy` is already low.
- **`wr_drop` timing.** Registered: a dropped write at edge j pulses `wr_drop` after edge j, for one cycle.
- **CLEAR_ON_RESET=1.** First zero write at the first edge after reset deasserts; `busy` is 1 from reset assertion.

## Test plan

- **Basic read/write, 3 ports** (NRD=3, DW=32, AW=7): write 0xDEADBEEF to address 5; next cycle set all `rd_a` = 5 -> all three `rd_d` = 0xDEADBEEF one cycle later. Read address 6 (never written, previously cleared) -> 0.
- **Bypass:** same-cycle `wr_en`, `wr_a`=9, `wr_d`=0x1234, `rd_a[0]`=9; old value 0xAAAA.
  - BYPASS=1 -> `rd_d[0]` = 0x1234.
  - BYPASS=0 -> `rd_d[0]` = 0xAAAA, then 0x1234 on a repeat read.
- **Clear:** fill all 128 addresses with their index; pulse `clear_start`.
  - `busy` is high for exactly 128 cycles.
  - `clear_done` pulses once, in the cycle `busy` falls.
  - A full readback on every port gives 0.
- **Write during clear:** assert `wr_en` (addr 3, data 0x55) at cycle 10 of the clear -> `wr_drop` pulses once, and address 3 reads 0 after the clear. A second `clear_start` during the clear is ignored: `busy` length stays 128.
- **Simultaneous and reset cases:**
  - `wr_en` + `clear_start` in the same cycle -> the clear still completes, and that address reads 0.
  - Pull `sys_rst_n` low at clear cycle 40 -> `busy` = 0 and `rd_d` = 0 immediately (asynchronous).
  - With CLEAR_ON_RESET=1, the same reset instead restarts the clear from address 0: `busy` lasts 128 cycles after release.
- **Parameter sweep:** NRD=1 and NRD=4, DW=8 and DW=64, AW=4 (DEPTH=16), with random writes and reads checked against a reference model. `clear_done` arrives at 16 cycles for AW=4.
